// File: rtl/fp_add_arbiter_if.sv
// ----------------------------------------------------------------------------
// fp_add_arbiter_if
// Purpose : bundles the requester, shared-adder and response signals of the
//           two-requester floating-point adder arbiter.
// Signals : req0_* / req1_*  operand pair handshake for each requester
//           add_a / add_b    registered operands driven to the shared adder
//           add_z            combinational sum returned by the adder
//           rsp_*            result handshake towards the consumer
//           busy             arbiter not idle
// Modports: slave  - the arbiter itself
//           master - the surrounding environment (requesters, adder, consumer)
// ----------------------------------------------------------------------------
interface fp_add_arbiter_if;
  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ready;

  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ready;

  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_z;

  logic        rsp_valid;
  logic [31:0] rsp_z;
  logic        rsp_id;
  logic        rsp_ready;

  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output add_a, add_b,
    input  add_z,
    output rsp_valid, rsp_z, rsp_id,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  add_a, add_b,
    output add_z,
    input  rsp_valid, rsp_z, rsp_id,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// ----------------------------------------------------------------------------
// fp_add_arbiter
// Purpose : shares one external IEEE-754 single-precision adder between two
//           requesters. A round-robin grant picks one operand pair in IDLE,
//           drives it to the adder from registers, waits ADD_LAT cycles,
//           captures the raw sum and holds it until the consumer takes it.
// Ports   : clk  - sole clock, rising edge
//           rst  - asynchronous active-high reset
//           bus  - fp_add_arbiter_if.slave (requesters, adder, response, busy)
// Params  : ADD_LAT - cycles from operand drive to sum capture, 1..15
// ----------------------------------------------------------------------------
module fp_add_arbiter #(
  parameter int ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  fp_add_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Counter value at which the adder output is considered settled.
  localparam logic [3:0] LAT_LAST = 4'(ADD_LAT - 1);

  state_t      state_r;
  state_t      state_next_s;

  logic        last_r;      // most recently granted requester
  logic [3:0]  cnt_r;       // cycles spent in ISSUE
  logic [31:0] add_a_r;
  logic [31:0] add_b_r;
  logic [31:0] rsp_z_r;
  logic        rsp_id_r;
  logic        rsp_valid_r;
  logic        busy_r;

  logic        grant_s;     // requester index that would win in IDLE
  logic        ready0_s;
  logic        ready1_s;
  logic        accept_s;
  logic        done_s;

  // Round-robin choice: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_s = ~last_r;
    end else if (bus.req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Ready is only offered in IDLE and only to the granted requester; rst masks
  // it because the async reset alone would leave IDLE's grant visible.
  always_comb begin
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    if (!rst && (state_r == IDLE)) begin
      ready0_s = bus.req0_valid && !grant_s;
      ready1_s = bus.req1_valid &&  grant_s;
    end else begin
      ready0_s = 1'b0;
      ready1_s = 1'b0;
    end
  end

  assign accept_s = ready0_s | ready1_s;
  assign done_s   = (state_r == ISSUE) && (cnt_r == LAT_LAST);

  // Next-state decode for the IDLE -> ISSUE -> HOLD cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (done_s) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = ISSUE;
        end
      end
      HOLD: begin
        // No bypass back into a grant: the next accept is one edge later.
        if (bus.rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand launch, latency counting, result capture and response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r      <= 1'b1;   // requester 0 wins the first tie
      cnt_r       <= 4'd0;
      add_a_r     <= 32'd0;
      add_b_r     <= 32'd0;
      rsp_z_r     <= 32'd0;
      rsp_id_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        add_a_r  <= grant_s ? bus.req1_a : bus.req0_a;
        add_b_r  <= grant_s ? bus.req1_b : bus.req0_b;
        rsp_id_r <= grant_s;
        last_r   <= grant_s;
        cnt_r    <= 4'd0;
      end else if (state_r == ISSUE) begin
        if (done_s) begin
          // Raw adder bits, no post-processing.
          rsp_z_r     <= bus.add_z;
          rsp_valid_r <= 1'b1;
        end else begin
          // Stops at LAT_LAST, so it cannot wrap for any legal ADD_LAT.
          cnt_r <= cnt_r + 4'd1;
        end
      end else if ((state_r == HOLD) && bus.rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end else begin
        rsp_valid_r <= rsp_valid_r;
      end
    end
  end

  // Busy follows the state being entered so it is a clean register output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
    end
  end

  assign bus.req0_ready = ready0_s;
  assign bus.req1_ready = ready1_s;
  assign bus.add_a      = add_a_r;
  assign bus.add_b      = add_b_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_z      = rsp_z_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fp_add_arbiter
// Purpose : directed, self-checking bench for fp_add_arbiter. A small lookup
//           adder stands in for the IEEE-754 adder (hand-computed sums). One
//           instance runs with ADD_LAT=1, a second with ADD_LAT=3.
// ----------------------------------------------------------------------------
module tb_fp_add_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fp_add_arbiter_if ifc ();
  fp_add_arbiter_if ifc3 ();

  fp_add_arbiter #(.ADD_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  fp_add_arbiter #(.ADD_LAT(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (ifc3.slave)
  );

  // Hand-computed single-precision sums for the operand pairs used here.
  function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] key;
    key = {a, b};
    case (key)
      64'h420F0000_41A40000: add_model = 32'h42610000; // 35.75 + 20.5 = 56.25
      64'h3F800000_3F800000: add_model = 32'h40000000; // 1 + 1 = 2
      64'h40400000_40800000: add_model = 32'h40E00000; // 3 + 4 = 7
      64'hBF800000_3F800000: add_model = 32'h00000000; // -1 + 1 = 0
      default:               add_model = a ^ b;
    endcase
  endfunction

  always_comb ifc.add_z  = add_model(ifc.add_a, ifc.add_b);
  always_comb ifc3.add_z = add_model(ifc3.add_a, ifc3.add_b);

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        v1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        exp_id;
    logic [31:0] exp_z;
  } vec_t;

  vec_t vecs [6];

  logic        ids  [8];
  logic [31:0] zs   [8];
  int          cyc  [8];
  int          got;

  // Global guard so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequence starts right after reset, so the first tie would favour requester 0.
    vecs[0] = '{1'b1, 32'h420F0000, 32'h41A40000, 1'b0, 32'hDEADBEEF, 32'h12345678, 1'b0, 32'h42610000};
    vecs[1] = '{1'b0, 32'hDEADBEEF, 32'h12345678, 1'b1, 32'h40400000, 32'h40800000, 1'b1, 32'h40E00000};
    vecs[2] = '{1'b1, 32'hBF800000, 32'h3F800000, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000};
    vecs[3] = '{1'b1, 32'hBF800000, 32'h3F800000, 1'b1, 32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000};
    vecs[4] = '{1'b0, 32'hDEADBEEF, 32'h12345678, 1'b1, 32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000};
    vecs[5] = '{1'b1, 32'h40400000, 32'h40800000, 1'b1, 32'hBF800000, 32'h3F800000, 1'b0, 32'h40E00000};

    rst = 1'b1;
    ifc.req0_valid = 1'b0; ifc.req0_a = 32'd0; ifc.req0_b = 32'd0;
    ifc.req1_valid = 1'b0; ifc.req1_a = 32'd0; ifc.req1_b = 32'd0;
    ifc.rsp_ready  = 1'b1;
    ifc3.req0_valid = 1'b0; ifc3.req0_a = 32'd0; ifc3.req0_b = 32'd0;
    ifc3.req1_valid = 1'b0; ifc3.req1_a = 32'd0; ifc3.req1_b = 32'd0;
    ifc3.rsp_ready  = 1'b1;

    // ---- reset state, ready masked even with both requesters valid ----
    #2;
    ifc.req0_valid = 1'b1;
    ifc.req1_valid = 1'b1;
    #1;
    check("rst_ready0", ifc.req0_ready, 1'b0);
    check("rst_ready1", ifc.req1_ready, 1'b0);
    check("rst_rsp_valid", ifc.rsp_valid, 1'b0);
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_add_a", ifc.add_a, 32'd0);
    check("rst_add_b", ifc.add_b, 32'd0);
    check("rst_rsp_z", ifc.rsp_z, 32'd0);
    check("rst_rsp_id", ifc.rsp_id, 1'b0);
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // ---- table-driven single operations, ADD_LAT=1 ----
    for (int i = 0; i < 6; i++) begin
      ifc.req0_valid = vecs[i].v0; ifc.req0_a = vecs[i].a0; ifc.req0_b = vecs[i].b0;
      ifc.req1_valid = vecs[i].v1; ifc.req1_a = vecs[i].a1; ifc.req1_b = vecs[i].b1;
      #1;
      check($sformatf("v%0d_ready0", i), ifc.req0_ready, !vecs[i].exp_id);
      check($sformatf("v%0d_ready1", i), ifc.req1_ready, vecs[i].exp_id);
      tick();  // accept edge
      ifc.req0_valid = 1'b0;
      ifc.req1_valid = 1'b0;
      check($sformatf("v%0d_add_a", i), ifc.add_a, vecs[i].exp_id ? vecs[i].a1 : vecs[i].a0);
      check($sformatf("v%0d_issue_valid", i), ifc.rsp_valid, 1'b0);
      check($sformatf("v%0d_issue_busy", i), ifc.busy, 1'b1);
      tick();  // capture edge
      check($sformatf("v%0d_rsp_valid", i), ifc.rsp_valid, 1'b1);
      check($sformatf("v%0d_rsp_z", i), ifc.rsp_z, vecs[i].exp_z);
      check($sformatf("v%0d_rsp_id", i), ifc.rsp_id, vecs[i].exp_id);
      check($sformatf("v%0d_hold_busy", i), ifc.busy, 1'b1);
      tick();  // consumer takes it
      check($sformatf("v%0d_idle_valid", i), ifc.rsp_valid, 1'b0);
      check($sformatf("v%0d_idle_busy", i), ifc.busy, 1'b0);
    end

    // ---- backpressure: last served was requester 0, so the tie goes to 1 ----
    ifc.rsp_ready  = 1'b0;
    ifc.req0_valid = 1'b1; ifc.req0_a = 32'h40400000; ifc.req0_b = 32'h40800000;
    ifc.req1_valid = 1'b1; ifc.req1_a = 32'h3F800000; ifc.req1_b = 32'h3F800000;
    #1;
    check("bp_ready1", ifc.req1_ready, 1'b1);
    check("bp_ready0", ifc.req0_ready, 1'b0);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_valid", k), ifc.rsp_valid, 1'b1);
      check($sformatf("bp%0d_z", k), ifc.rsp_z, 32'h40000000);
      check($sformatf("bp%0d_id", k), ifc.rsp_id, 1'b1);
      check($sformatf("bp%0d_ready0", k), ifc.req0_ready, 1'b0);
      check($sformatf("bp%0d_ready1", k), ifc.req1_ready, 1'b0);
      tick();
    end
    ifc.rsp_ready = 1'b1;
    #1;
    check("bp_release_still_valid", ifc.rsp_valid, 1'b1);
    tick();
    check("bp_release_valid", ifc.rsp_valid, 1'b0);
    check("bp_release_busy", ifc.busy, 1'b0);
    check("bp_next_ready0", ifc.req0_ready, 1'b1);
    check("bp_next_ready1", ifc.req1_ready, 1'b0);
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    tick();

    // ---- reset in the middle of an operation ----
    ifc.req0_valid = 1'b1; ifc.req0_a = 32'h420F0000; ifc.req0_b = 32'h41A40000;
    #1;
    check("mr_ready0", ifc.req0_ready, 1'b1);
    tick();
    ifc.req0_valid = 1'b0;
    check("mr_issue_busy", ifc.busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_busy", ifc.busy, 1'b0);
    check("mr_rsp_valid", ifc.rsp_valid, 1'b0);
    check("mr_add_a", ifc.add_a, 32'd0);
    check("mr_add_b", ifc.add_b, 32'd0);
    check("mr_rsp_z", ifc.rsp_z, 32'd0);
    check("mr_rsp_id", ifc.rsp_id, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mr_discard%0d", k), ifc.rsp_valid, 1'b0);
    end
    ifc.req1_valid = 1'b1; ifc.req1_a = 32'h3F800000; ifc.req1_b = 32'h3F800000;
    #1;
    check("mr_new_ready1", ifc.req1_ready, 1'b1);
    tick();
    ifc.req1_valid = 1'b0;
    tick();
    check("mr_new_valid", ifc.rsp_valid, 1'b1);
    check("mr_new_z", ifc.rsp_z, 32'h40000000);
    check("mr_new_id", ifc.rsp_id, 1'b1);
    tick();
    check("mr_new_done", ifc.rsp_valid, 1'b0);

    // ---- ADD_LAT=3 latency ----
    ifc3.req0_valid = 1'b1; ifc3.req0_a = 32'h40400000; ifc3.req0_b = 32'h40800000;
    #1;
    check("l3_ready0", ifc3.req0_ready, 1'b1);
    tick();  // accept edge T
    ifc3.req0_valid = 1'b0;
    check("l3_t0_valid", ifc3.rsp_valid, 1'b0);
    tick();
    check("l3_t1_valid", ifc3.rsp_valid, 1'b0);
    tick();
    check("l3_t2_valid", ifc3.rsp_valid, 1'b0);
    check("l3_t2_busy", ifc3.busy, 1'b1);
    tick();
    check("l3_t3_valid", ifc3.rsp_valid, 1'b1);
    check("l3_t3_z", ifc3.rsp_z, 32'h40E00000);
    check("l3_t3_id", ifc3.rsp_id, 1'b0);
    tick();
    check("l3_done", ifc3.rsp_valid, 1'b0);

    // ---- tie after reset and fairness over 8 back-to-back ops ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.req0_valid = 1'b1; ifc.req0_a = 32'h420F0000; ifc.req0_b = 32'h41A40000;
    ifc.req1_valid = 1'b1; ifc.req1_a = 32'h3F800000; ifc.req1_b = 32'h3F800000;
    got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      tick();
      if (ifc.rsp_valid) begin
        ids[got] = ifc.rsp_id;
        zs[got]  = ifc.rsp_z;
        cyc[got] = c;
        got++;
      end
    end
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    check("fair_count", got, 8);
    for (int k = 0; k < got; k++) begin
      check($sformatf("fair%0d_id", k), ids[k], k % 2);
      check($sformatf("fair%0d_z", k), zs[k], (k % 2 == 1) ? 32'h40000000 : 32'h42610000);
      if (k > 0) begin
        check($sformatf("fair%0d_gap", k), cyc[k] - cyc[k-1], 3);
      end
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
